// File: rtl/wb_stage_pkg.sv
// Shared definitions for the write-back stage and the control unit that feeds it.
package wb_stage_pkg;

    localparam int unsigned DATA_W_DEF = 32;
    localparam int unsigned ADDR_W_DEF = 5;
    localparam int unsigned CNT_W_DEF  = 32;

    // Register index hard-wired to zero; writes to it are discarded.
    localparam int unsigned REG_ZERO = 0;

    // Write-back control bundle produced by decode/control and carried to WB.
    typedef struct packed {
        logic reg_write;
        logic mem_to_reg;
        logic reg_dst;
    } wb_ctrl_t;

endpackage

// File: rtl/wb_pipe_reg.sv
// MEM/WB pipeline register: asynchronous active-low reset, flush turns the
// entry being captured into a bubble.
module wb_pipe_reg
    import wb_stage_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    input  wb_ctrl_t          in_ctrl,
    input  logic [ADDR_W-1:0] in_rt,
    input  logic [ADDR_W-1:0] in_rd,
    input  logic [DATA_W-1:0] in_alu_result,
    input  logic [DATA_W-1:0] in_mem_data,
    output logic              valid_o,
    output wb_ctrl_t          ctrl_o,
    output logic [ADDR_W-1:0] rt_o,
    output logic [ADDR_W-1:0] rd_o,
    output logic [DATA_W-1:0] alu_result_o,
    output logic [DATA_W-1:0] mem_data_o
);

    logic              valid_q,      valid_d;
    wb_ctrl_t          ctrl_q,       ctrl_d;
    logic [ADDR_W-1:0] rt_q,         rt_d;
    logic [ADDR_W-1:0] rd_q,         rd_d;
    logic [DATA_W-1:0] alu_result_q, alu_result_d;
    logic [DATA_W-1:0] mem_data_q,   mem_data_d;

    // Next entry: every field is loaded each cycle; flush overrides in_valid.
    always_comb begin
        valid_d      = in_valid & ~flush;
        ctrl_d       = in_ctrl;
        rt_d         = in_rt;
        rd_d         = in_rd;
        alu_result_d = in_alu_result;
        mem_data_d   = in_mem_data;
    end

    // Stage register with asynchronous clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q      <= 1'b0;
            ctrl_q       <= '0;
            rt_q         <= '0;
            rd_q         <= '0;
            alu_result_q <= '0;
            mem_data_q   <= '0;
        end else begin
            valid_q      <= valid_d;
            ctrl_q       <= ctrl_d;
            rt_q         <= rt_d;
            rd_q         <= rd_d;
            alu_result_q <= alu_result_d;
            mem_data_q   <= mem_data_d;
        end
    end

    assign valid_o      = valid_q;
    assign ctrl_o       = ctrl_q;
    assign rt_o         = rt_q;
    assign rd_o         = rd_q;
    assign alu_result_o = alu_result_q;
    assign mem_data_o   = mem_data_q;

endmodule

// File: rtl/wb_stage.sv
// Write-back stage: MEM/WB register, write-back source select, $zero write
// suppression, same-cycle bypass to decode and a retired-instruction counter.
module wb_stage
    import wb_stage_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned CNT_W  = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    input  logic              in_reg_write,
    input  logic              in_mem_to_reg,
    input  logic              in_reg_dst,
    input  logic [ADDR_W-1:0] in_rt,
    input  logic [ADDR_W-1:0] in_rd,
    input  logic [DATA_W-1:0] in_alu_result,
    input  logic [DATA_W-1:0] in_mem_data,
    input  logic [ADDR_W-1:0] rs_addr,
    input  logic [ADDR_W-1:0] rt_addr,
    output logic              reg_write,
    output logic [ADDR_W-1:0] write_reg,
    output logic [DATA_W-1:0] write_data,
    output logic              wb_valid,
    output logic              rs_fwd,
    output logic              rt_fwd,
    output logic [CNT_W-1:0]  retire_count
);

    wb_ctrl_t          in_ctrl;
    wb_ctrl_t          ctrl_r;
    logic              valid_r;
    logic [ADDR_W-1:0] rt_r;
    logic [ADDR_W-1:0] rd_r;
    logic [DATA_W-1:0] alu_result_r;
    logic [DATA_W-1:0] mem_data_r;

    logic [CNT_W-1:0]  retire_count_q, retire_count_d;

    assign in_ctrl = '{reg_write: in_reg_write, mem_to_reg: in_mem_to_reg, reg_dst: in_reg_dst};

    wb_pipe_reg #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_pipe_reg (
        .clk           (clk),
        .reset         (reset),
        .flush         (flush),
        .in_valid      (in_valid),
        .in_ctrl       (in_ctrl),
        .in_rt         (in_rt),
        .in_rd         (in_rd),
        .in_alu_result (in_alu_result),
        .in_mem_data   (in_mem_data),
        .valid_o       (valid_r),
        .ctrl_o        (ctrl_r),
        .rt_o          (rt_r),
        .rd_o          (rd_r),
        .alu_result_o  (alu_result_r),
        .mem_data_o    (mem_data_r)
    );

    // Register-file write port and decode bypass, all from the held entry.
    always_comb begin
        write_reg  = ctrl_r.reg_dst    ? rd_r       : rt_r;
        write_data = ctrl_r.mem_to_reg ? mem_data_r : alu_result_r;
        reg_write  = valid_r & ctrl_r.reg_write & (write_reg != ADDR_W'(REG_ZERO));
        wb_valid   = valid_r;
        rs_fwd     = reg_write & (rs_addr == write_reg);
        rt_fwd     = reg_write & (rt_addr == write_reg);
    end

    // Every valid entry retires on the edge that replaces it; wraps freely.
    always_comb begin
        retire_count_d = retire_count_q + CNT_W'(valid_r);
    end

    // Retire counter register with asynchronous clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            retire_count_q <= '0;
        end else begin
            retire_count_q <= retire_count_d;
        end
    end

    assign retire_count = retire_count_q;

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: directed vectors feed a scoreboard queue,
// a negedge monitor compares the registered outputs one cycle later.
module tb_wb_stage;

    logic        clk;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        in_reg_write;
    logic        in_mem_to_reg;
    logic        in_reg_dst;
    logic [4:0]  in_rt;
    logic [4:0]  in_rd;
    logic [31:0] in_alu_result;
    logic [31:0] in_mem_data;
    logic [4:0]  rs_addr;
    logic [4:0]  rt_addr;

    logic        reg_write;
    logic [4:0]  write_reg;
    logic [31:0] write_data;
    logic        wb_valid;
    logic        rs_fwd;
    logic        rt_fwd;
    logic [31:0] retire_count;

    // Narrow-counter instance to observe wrap-around.
    logic        s_reg_write;
    logic [4:0]  s_write_reg;
    logic [31:0] s_write_data;
    logic        s_wb_valid;
    logic        s_rs_fwd;
    logic        s_rt_fwd;
    logic [2:0]  s_retire_count;

    wb_stage u_dut (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid),
        .in_reg_write(in_reg_write), .in_mem_to_reg(in_mem_to_reg), .in_reg_dst(in_reg_dst),
        .in_rt(in_rt), .in_rd(in_rd), .in_alu_result(in_alu_result), .in_mem_data(in_mem_data),
        .rs_addr(rs_addr), .rt_addr(rt_addr),
        .reg_write(reg_write), .write_reg(write_reg), .write_data(write_data),
        .wb_valid(wb_valid), .rs_fwd(rs_fwd), .rt_fwd(rt_fwd), .retire_count(retire_count)
    );

    wb_stage #(.CNT_W(3)) u_dut_w3 (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid),
        .in_reg_write(in_reg_write), .in_mem_to_reg(in_mem_to_reg), .in_reg_dst(in_reg_dst),
        .in_rt(in_rt), .in_rd(in_rd), .in_alu_result(in_alu_result), .in_mem_data(in_mem_data),
        .rs_addr(rs_addr), .rt_addr(rt_addr),
        .reg_write(s_reg_write), .write_reg(s_write_reg), .write_data(s_write_data),
        .wb_valid(s_wb_valid), .rs_fwd(s_rs_fwd), .rt_fwd(s_rt_fwd), .retire_count(s_retire_count)
    );

    typedef struct {
        bit        v, fl, rw, m2r, dst;
        bit [4:0]  rt, rd;
        bit [31:0] alu, mem;
        bit [4:0]  rs_a, rt_a;
        bit        chk_fields;
        bit        e_rw;
        bit [4:0]  e_wreg;
        bit [31:0] e_wdata;
        bit        e_valid, e_rsf, e_rtf;
        bit [31:0] e_cnt;
    } vec_t;

    typedef struct {
        int   due;
        int   idx;
        vec_t v;
    } exp_t;

    localparam int NV = 9;
    vec_t vecs[NV];
    exp_t sb[$];

    int pass_cnt  = 0;
    int total_cnt = 0;
    int cyc       = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    function automatic vec_t mk(bit v, bit fl, bit rw, bit m2r, bit dst, bit [4:0] rt, bit [4:0] rd,
                                bit [31:0] alu, bit [31:0] mem, bit [4:0] rs_a, bit [4:0] rt_a,
                                bit chk_fields, bit e_rw, bit [4:0] e_wreg, bit [31:0] e_wdata,
                                bit e_valid, bit e_rsf, bit e_rtf, bit [31:0] e_cnt);
        vec_t r;
        r.v = v; r.fl = fl; r.rw = rw; r.m2r = m2r; r.dst = dst;
        r.rt = rt; r.rd = rd; r.alu = alu; r.mem = mem; r.rs_a = rs_a; r.rt_a = rt_a;
        r.chk_fields = chk_fields; r.e_rw = e_rw; r.e_wreg = e_wreg; r.e_wdata = e_wdata;
        r.e_valid = e_valid; r.e_rsf = e_rsf; r.e_rtf = e_rtf; r.e_cnt = e_cnt;
        return r;
    endfunction

    // Monitor: compare every due expectation against the held entry.
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            exp_t e;
            logic [39:0] s_act, s_exp;
            e = sb.pop_front();
            if (e.due < cyc) begin
                chk($sformatf("v%0d_missed_cycle", e.idx), 64'(cyc), 64'(e.due));
            end else begin
                chk($sformatf("v%0d_reg_write", e.idx), 64'(reg_write), 64'(e.v.e_rw));
                chk($sformatf("v%0d_wb_valid", e.idx), 64'(wb_valid), 64'(e.v.e_valid));
                chk($sformatf("v%0d_rs_fwd", e.idx), 64'(rs_fwd), 64'(e.v.e_rsf));
                chk($sformatf("v%0d_rt_fwd", e.idx), 64'(rt_fwd), 64'(e.v.e_rtf));
                chk($sformatf("v%0d_retire_count", e.idx), 64'(retire_count), 64'(e.v.e_cnt));
                if (e.v.chk_fields) begin
                    chk($sformatf("v%0d_write_reg", e.idx), 64'(write_reg), 64'(e.v.e_wreg));
                    chk($sformatf("v%0d_write_data", e.idx), 64'(write_data), 64'(e.v.e_wdata));
                end
                s_act = {s_reg_write, s_wb_valid, s_rs_fwd, s_rt_fwd,
                         e.v.chk_fields ? s_write_reg : 5'd0,
                         e.v.chk_fields ? s_write_data : 32'd0, s_retire_count};
                s_exp = {e.v.e_rw, e.v.e_valid, e.v.e_rsf, e.v.e_rtf,
                         e.v.chk_fields ? e.v.e_wreg : 5'd0,
                         e.v.chk_fields ? e.v.e_wdata : 32'd0, e.v.e_cnt[2:0]};
                chk($sformatf("v%0d_narrow_outputs", e.idx), 64'(s_act), 64'(s_exp));
            end
        end
    end

    task automatic drive(input bit v, input bit fl, input bit rw, input bit m2r, input bit dst,
                         input bit [4:0] rt, input bit [4:0] rd, input bit [31:0] alu, input bit [31:0] mem);
        in_valid = v; flush = fl; in_reg_write = rw; in_mem_to_reg = m2r; in_reg_dst = dst;
        in_rt = rt; in_rd = rd; in_alu_result = alu; in_mem_data = mem;
    endtask

    initial begin
        //              v fl rw m2r dst rt  rd  alu           mem           rs  rt_a chk e_rw wreg wdata         val rsf rtf cnt
        vecs[0] = mk(1, 0, 1, 0, 1, 5'd3,  5'd9,  32'h0000_00AB, 32'h0000_0055, 5'd9,  5'd1,  1, 1, 5'd9,  32'h0000_00AB, 1, 1, 0, 0);
        vecs[1] = mk(1, 0, 1, 1, 0, 5'd17, 5'd2,  32'h0000_0010, 32'hDEAD_BEEF, 5'd0,  5'd17, 1, 1, 5'd17, 32'hDEAD_BEEF, 1, 0, 1, 1);
        vecs[2] = mk(1, 0, 1, 0, 1, 5'd4,  5'd0,  32'h0000_0123, 32'h0000_0000, 5'd0,  5'd0,  1, 0, 5'd0,  32'h0000_0123, 1, 0, 0, 2);
        vecs[3] = mk(1, 0, 1, 0, 1, 5'd1,  5'd5,  32'h0000_5555, 32'h0000_0000, 5'd5,  5'd5,  1, 1, 5'd5,  32'h0000_5555, 1, 1, 1, 3);
        vecs[4] = mk(1, 0, 1, 0, 1, 5'd1,  5'd5,  32'h0000_5555, 32'h0000_0000, 5'd5,  5'd6,  1, 1, 5'd5,  32'h0000_5555, 1, 1, 0, 4);
        vecs[5] = mk(1, 0, 0, 0, 0, 5'd5,  5'd0,  32'h0000_0020, 32'h0000_0000, 5'd5,  5'd5,  1, 0, 5'd5,  32'h0000_0020, 1, 0, 0, 5);
        vecs[6] = mk(1, 1, 1, 0, 1, 5'd1,  5'd7,  32'h0000_0077, 32'h0000_0000, 5'd7,  5'd7,  0, 0, 5'd0,  32'h0,         0, 0, 0, 6);
        vecs[7] = mk(0, 0, 1, 0, 1, 5'd1,  5'd8,  32'h0000_0088, 32'h0000_0000, 5'd8,  5'd8,  0, 0, 5'd0,  32'h0,         0, 0, 0, 6);
        vecs[8] = mk(1, 0, 1, 1, 1, 5'd2,  5'd31, 32'h0000_0031, 32'hFFFF_FFFF, 5'd31, 5'd30, 1, 1, 5'd31, 32'hFFFF_FFFF, 1, 1, 0, 6);

        reset = 1'b0;
        drive(0, 0, 0, 0, 0, 5'd0, 5'd0, 32'd0, 32'd0);
        rs_addr = 5'd0;
        rt_addr = 5'd0;

        // Reset state.
        #3;
        chk("reset_reg_write", 64'(reg_write), 64'd0);
        chk("reset_wb_valid", 64'(wb_valid), 64'd0);
        chk("reset_write_reg", 64'(write_reg), 64'd0);
        chk("reset_write_data", 64'(write_data), 64'd0);
        chk("reset_retire_count", 64'(retire_count), 64'd0);
        #9 reset = 1'b1;

        // Directed vectors through the scoreboard.
        for (int i = 0; i <= NV; i++) begin
            @(posedge clk);
            #1;
            if (i < NV) drive(vecs[i].v, vecs[i].fl, vecs[i].rw, vecs[i].m2r, vecs[i].dst,
                              vecs[i].rt, vecs[i].rd, vecs[i].alu, vecs[i].mem);
            else        drive(0, 0, 0, 0, 0, 5'd0, 5'd0, 32'd0, 32'd0);
            if (i > 0) begin
                rs_addr = vecs[i-1].rs_a;
                rt_addr = vecs[i-1].rt_a;
            end
            if (i < NV) sb.push_back('{due: cyc + 1, idx: i, v: vecs[i]});
        end

        for (int k = 0; k < 10 && sb.size() > 0; k++) @(negedge clk);
        if (sb.size() > 0) begin
            chk("scoreboard_drain_timeout", 64'(sb.size()), 64'd0);
            sb.delete();
        end

        // Counter now 7: two more valid writes take it to 8 (narrow one wraps).
        rs_addr = 5'd0;
        rt_addr = 5'd0;
        @(posedge clk); #1;
        drive(1, 0, 1, 0, 1, 5'd0, 5'd12, 32'h0000_000C, 32'd0);
        @(posedge clk); #1;
        drive(1, 0, 1, 0, 1, 5'd0, 5'd13, 32'h0000_000D, 32'd0);
        @(posedge clk); #2;
        chk("pre_reset_retire_count", 64'(retire_count), 64'd8);
        chk("narrow_counter_wrap", 64'(s_retire_count), 64'd0);
        chk("pre_reset_reg_write", 64'(reg_write), 64'd1);
        chk("pre_reset_write_reg", 64'(write_reg), 64'd13);

        // Asynchronous reset mid-cycle with a write pending.
        reset = 1'b0;
        drive(0, 0, 0, 0, 0, 5'd0, 5'd0, 32'd0, 32'd0);
        #1;
        chk("async_reg_write", 64'(reg_write), 64'd0);
        chk("async_retire_count", 64'(retire_count), 64'd0);
        chk("async_wb_valid", 64'(wb_valid), 64'd0);
        chk("async_write_reg", 64'(write_reg), 64'd0);
        chk("async_write_data", 64'(write_data), 64'd0);
        @(negedge clk);
        reset = 1'b1;

        // One instruction after reset.
        @(posedge clk); #1;
        drive(1, 0, 1, 0, 1, 5'd0, 5'd14, 32'h0000_000E, 32'd0);
        @(posedge clk); #1;
        drive(0, 0, 0, 0, 0, 5'd0, 5'd0, 32'd0, 32'd0);
        chk("post_reset_wb_valid", 64'(wb_valid), 64'd1);
        chk("post_reset_count_before", 64'(retire_count), 64'd0);
        @(posedge clk); #1;
        chk("post_reset_retire_count", 64'(retire_count), 64'd1);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", pass_cnt, total_cnt);
        $fatal(1, "watchdog");
    end

endmodule
